// File: rtl/bcd_mmss_timer_pkg.sv
// ============================================================================
// Module   : bcd_mmss_timer_pkg
// Purpose  : Shared state encoding and BCD constants for the mm:ss timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_mmss_timer_pkg;

    localparam int c_bcd_w = 4;

    localparam logic [c_bcd_w-1:0] c_sec_tens_max = 4'd5;
    localparam logic [c_bcd_w-1:0] c_digit_max    = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module   : bcd_digit
// Purpose  : Single BCD digit counter with synchronous clear and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import bcd_mmss_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic [c_bcd_w-1:0] max,
    output logic [c_bcd_w-1:0] digit,
    output logic               carry
);

    logic [c_bcd_w-1:0] r_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else if (clear) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit == max) ? '0 : r_digit + 1'b1;
        end
    end

    assign digit = r_digit;
    assign carry = inc && (r_digit == max);

endmodule

`default_nettype wire

// File: rtl/bcd_mmss_timer.sv
// ============================================================================
// Module   : bcd_mmss_timer
// Purpose  : BCD mm:ss timer with run/pause/idle control; optional lap hold
//            enabled by BCD_TIMER_LAP_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mmss_timer
    import bcd_mmss_timer_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start_stop,
    input  logic               clear,
`ifdef BCD_TIMER_LAP_HOLD_EN
    input  logic               lap,
`endif
    output logic [c_bcd_w-1:0] sec_ones,
    output logic [c_bcd_w-1:0] sec_tens,
    output logic [c_bcd_w-1:0] min_ones,
    output logic [c_bcd_w-1:0] min_tens,
    output logic               running,
    output logic               rollover
);

    localparam logic [c_bcd_w-1:0] c_lim_tens = c_bcd_w'(MIN_LIMIT / 10);
    localparam logic [c_bcd_w-1:0] c_lim_ones = c_bcd_w'(MIN_LIMIT % 10);

    state_t             r_state;
    state_t             w_next;
    logic               r_ss_q;
    logic               r_clr_q;
    logic               r_running;
    logic               r_rollover;
    logic               w_ss_edge;
    logic               w_clr_edge;
    logic               w_count;
    logic               w_wrap;
    logic               w_dig_clr;
    logic               w_s1_carry;
    logic               w_s10_carry;
    logic               w_m1_carry;
    logic               w_m10_carry;
    logic               w_unused;
    logic [c_bcd_w-1:0] w_s1;
    logic [c_bcd_w-1:0] w_s10;
    logic [c_bcd_w-1:0] w_m1;
    logic [c_bcd_w-1:0] w_m10;

    assign w_ss_edge  = start_stop & ~r_ss_q;
    assign w_clr_edge = clear & ~r_clr_q;

    // Counting looks at the registered state, before this cycle's transition.
    assign w_count = (r_state == RUN) && tick;

    assign w_wrap = w_count && !w_clr_edge
                 && (w_m10 == c_lim_tens) && (w_m1 == c_lim_ones)
                 && (w_s10 == c_sec_tens_max) && (w_s1 == c_digit_max);

    assign w_dig_clr = w_clr_edge | w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ss_q     <= 1'b0;
            r_clr_q    <= 1'b0;
            r_running  <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ss_q     <= start_stop;
            r_clr_q    <= clear;
            r_running  <= (w_next == RUN);
            r_rollover <= w_wrap;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_clr_edge) begin
            w_next = IDLE;
        end else if (w_ss_edge) begin
            case (r_state)
                IDLE:    w_next = RUN;
                RUN:     w_next = PAUSE;
                PAUSE:   w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    bcd_digit u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clear (w_dig_clr),
        .inc   (w_count),
        .max   (c_digit_max),
        .digit (w_s1),
        .carry (w_s1_carry)
    );

    bcd_digit u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clear (w_dig_clr),
        .inc   (w_s1_carry),
        .max   (c_sec_tens_max),
        .digit (w_s10),
        .carry (w_s10_carry)
    );

    bcd_digit u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clear (w_dig_clr),
        .inc   (w_s10_carry),
        .max   (c_digit_max),
        .digit (w_m1),
        .carry (w_m1_carry)
    );

    // Minutes wrap is forced by w_wrap, so the tens carry-out is not needed.
    bcd_digit u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clear (w_dig_clr),
        .inc   (w_m1_carry),
        .max   (c_digit_max),
        .digit (w_m10),
        .carry (w_m10_carry)
    );

    assign w_unused = w_m10_carry;

`ifdef BCD_TIMER_LAP_HOLD_EN
    logic                   r_lap_q;
    logic                   r_hold;
    logic [4*c_bcd_w-1:0]   r_frz;
    logic                   w_lap_edge;

    assign w_lap_edge = lap & ~r_lap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_q <= 1'b0;
            r_hold  <= 1'b0;
            r_frz   <= '0;
        end else begin
            r_lap_q <= lap;
            if (w_clr_edge) begin
                r_hold <= 1'b0;
            end else if (w_lap_edge && (r_state == RUN)) begin
                r_hold <= ~r_hold;
                r_frz  <= {w_m10, w_m1, w_s10, w_s1};
            end
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} =
        r_hold ? r_frz : {w_m10, w_m1, w_s10, w_s1};
`else
    assign {min_tens, min_ones, sec_tens, sec_ones} = {w_m10, w_m1, w_s10, w_s1};
`endif

    assign running  = r_running;
    assign rollover = r_rollover;

endmodule

`default_nettype wire

// File: tb/tb_bcd_mmss_timer.sv
// ============================================================================
// Module   : tb_bcd_mmss_timer
// Purpose  : Self-checking bench for bcd_mmss_timer against a seconds-count
//            reference model; lap checks when BCD_TIMER_LAP_HOLD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_mmss_timer;

    localparam int MIN_LIMIT = 59;
    localparam int LAST_SEC  = (MIN_LIMIT + 1) * 60 - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;

    always #5 clk = ~clk;

    bcd_mmss_timer #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef BCD_TIMER_LAP_HOLD_EN
        .lap        (lap),
`endif
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .rollover   (rollover)
    );

    // Reference model: elapsed seconds, mode 0=idle 1=run 2=pause
    int  m_secs, m_mode, m_frz;
    bit  m_hold, m_roll;
    bit  p_ss, p_clr, p_lap;
    int  n_vec, n_err;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_mode = 0; m_frz = 0;
        m_hold = 0; m_roll = 0;
        p_ss = 0; p_clr = 0; p_lap = 0;
    endtask

    task automatic cyc(input bit t, input bit s, input bit c, input bit l);
        bit se, ce, le;
        tick = t; start_stop = s; clear = c; lap = l;
        @(posedge clk);
        #1;
        se = s && !p_ss;
        ce = c && !p_clr;
`ifdef BCD_TIMER_LAP_HOLD_EN
        le = l && !p_lap;
`else
        le = 1'b0;
`endif
        m_roll = 0;
        if (ce) begin
            m_secs = 0; m_mode = 0; m_hold = 0;
        end else begin
            if (le && m_mode == 1) begin
                m_hold = !m_hold;
                m_frz  = m_secs;
            end
            if (m_mode == 1 && t) begin
                if (m_secs == LAST_SEC) begin
                    m_secs = 0;
                    m_roll = 1;
                end else begin
                    m_secs++;
                end
            end
            if (se) m_mode = (m_mode == 1) ? 2 : 1;
        end
        p_ss = s; p_clr = c; p_lap = l;
        chk("digits",   disp(),            to_bcd(m_hold ? m_frz : m_secs));
        chk("running",  16'(running),      16'(m_mode == 1));
        chk("rollover", 16'(rollover),     16'(m_roll));
    endtask

    // Random tick spacing until n ticks have been applied
    task automatic run_ticks(input int n, input bit l);
        int k;
        bit t;
        k = 0;
        while (k < n) begin
            t = 1'($urandom_range(0, 1));
            cyc(t, 1'b0, 1'b0, l);
            if (t) k++;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; tick = 0; start_stop = 0; clear = 0; lap = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_digits",   disp(),         16'h0000);
        chk("reset_running",  16'(running),   16'h0000);
        chk("reset_rollover", 16'(rollover),  16'h0000);
        #2 reset = 1'b0;

        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("enter_tick_dropped", disp(), 16'h0000);
        run_ticks(75, 0);
        chk("disp_0115", disp(), 16'h0115);
        chk("run_0115",  16'(running), 16'h0001);

        run_ticks(754 - 75, 0);
        chk("disp_1234", disp(), 16'h1234);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digits",  disp(),       16'h0000);
        chk("async_rst_running", 16'(running), 16'h0000);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) cyc(1, 0, 0, 0);

        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        run_ticks(59, 0);
        chk("disp_0059", disp(), 16'h0059);
        run_ticks(1, 0);
        chk("disp_0100", disp(), 16'h0100);
        run_ticks(539, 0);
        chk("disp_0959", disp(), 16'h0959);
        run_ticks(1, 0);
        chk("disp_1000", disp(), 16'h1000);

        run_ticks(LAST_SEC - 600, 0);
        chk("disp_5959", disp(), 16'h5959);
        cyc(1, 0, 0, 0);
        chk("wrap_digits",   disp(),         16'h0000);
        chk("wrap_rollover", 16'(rollover),  16'h0001);
        chk("wrap_running",  16'(running),   16'h0001);
        cyc(0, 0, 0, 0);
        chk("rollover_one_cycle", 16'(rollover), 16'h0000);

        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        run_ticks(30, 0);
        cyc(0, 1, 0, 0);
        repeat (10) cyc(1, 0, 0, 0);
        chk("pause_0030",    disp(),       16'h0030);
        chk("pause_running", 16'(running), 16'h0000);

        repeat (20) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("held_ss_0049",    disp(),       16'h0049);
        chk("held_ss_running", 16'(running), 16'h0001);

        cyc(0, 1, 1, 0);
        chk("clr_ss_digits",  disp(),       16'h0000);
        chk("clr_ss_running", 16'(running), 16'h0000);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        run_ticks(7, 0);
        cyc(1, 0, 1, 0);
        chk("clr_tick_digits", disp(), 16'h0000);
        cyc(0, 0, 0, 0);

`ifdef BCD_TIMER_LAP_HOLD_EN
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        run_ticks(10, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        run_ticks(5, 1);
        chk("lap_hold_0010", disp(), 16'h0010);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("lap_release_0015", disp(), 16'h0015);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        run_ticks(3, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        run_ticks(4, 0);
        chk("lap_in_pause_ignored", disp(), 16'h0019);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_mmss_timer.md
Name: bcd_mmss_timer

Overview:
- Downstream consumer of the 4-bit counter's carry-out (CO) chain.
- Takes a one-cycle tick pulse per second and keeps a BCD minutes:seconds time (00:00 to 59:59).
- A run/pause/idle state machine is controlled by START_STOP and CLEAR inputs.
- Outputs feed the seven-segment display driver directly as four BCD digits.

Parameters:
- MIN_LIMIT, default 59: highest minute value before wrap to 00:00. Legal range 1..99.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- TICK  input  1  one-cycle count pulse, normally the upstream counter's CO.
- START_STOP  input  1  debounced level button; the rising edge toggles run/pause.
- CLEAR  input  1  debounced level button; the rising edge zeroes the time and returns to IDLE.
- SEC_ONES  output  4  BCD seconds units, 0..9.
- SEC_TENS  output  4  BCD seconds tens, 0..5.
- MIN_ONES  output  4  BCD minutes units, 0..9.
- MIN_TENS  output  4  BCD minutes tens, 0..9, bounded by MIN_LIMIT.
- RUNNING  output  1  high while in RUN.
- ROLLOVER  output  1  one-cycle pulse on wrap from MIN_LIMIT:59 to 00:00.

Behaviour:
- Reset (asynchronous, active-high): every digit is 0, RUNNING=0, ROLLOVER=0, state=IDLE, edge-detect registers=0. Reset asserted mid-count aborts immediately, with no partial update.
- Edge detect: START_STOP and CLEAR are each registered once. A rising edge is current=1 and previous=0. A held button produces exactly one event.
- State machine, states IDLE, RUN, PAUSE:
  - IDLE, on START_STOP edge -> RUN.
  - RUN, on START_STOP edge -> PAUSE.
  - PAUSE, on START_STOP edge -> RUN.
  - Any state, on CLEAR edge -> IDLE with all digits zeroed.
  - CLEAR edge and START_STOP edge in the same cycle: CLEAR wins, next state is IDLE.
- Counting:
  - Counting happens only when the registered state is RUN and TICK=1. Counting uses the state before that cycle's transition.
  - A TICK arriving in the same cycle as the START_STOP edge that enters RUN is not counted.
  - A TICK arriving in the same cycle as the edge that leaves RUN is counted.
- Digit carry on each counted tick:
  - SEC_ONES 9 -> 0 carries into SEC_TENS.
  - SEC_TENS 5 -> 0 carries into the minutes.
  - Minutes increment as a two-digit BCD value; MIN_ONES 9 -> 0 carries into MIN_TENS.
  - When minutes = MIN_LIMIT and seconds = 59, all digits become 0, ROLLOVER pulses high for exactly one cycle, and the state stays RUN.
- Latency: digits update on the CLK edge following the cycle in which TICK is sampled high (1 cycle). RUNNING is a registered decode of the state.
- TICK and CLEAR edge in the same cycle: the clear wins, digits go to 0, and the tick is dropped.
- Digits are never outside BCD range; no invalid codes are reachable from reset.

Optional Feature:
- Macro: BCD_TIMER_LAP_HOLD_EN.
- When defined:
  - Adds input LAP (debounced level).
  - A LAP rising edge while in RUN toggles a hold flag.
  - While hold=1, the four digit outputs are frozen at their value at the hold moment, and internal counting continues.
  - A second LAP edge releases the hold, and the outputs show live time on the next cycle.
  - A CLEAR edge or RESET also releases the hold.
  - A LAP edge while in IDLE or PAUSE is ignored.
  - ROLLOVER and RUNNING are never frozen.
- When undefined: no LAP port, no hold registers; the outputs are always the live digits.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10;
  - the BCD digit width constant (4);
  - the seconds-tens limit constant (5).
- One natural sub-module: bcd_digit, a single BCD digit counter.
  - Inputs: CLK, RESET, clear, inc, and a max value.
  - Outputs: the digit and a carry that is high when inc=1 and the digit is at its max.
  - Instantiated four times. For the minutes pair, the wrap at MIN_LIMIT is handled by top-level compare logic that forces clear.

Test Plan:
- RESET pulse in mid-run at 12:34 -> all digits 0, RUNNING=0, state IDLE immediately (asynchronous). A later TICK is ignored until a START_STOP edge.
- START_STOP edge, then 75 TICKs -> display 01:15, RUNNING=1. A TICK in the same cycle as the entering edge is not counted.
- Preload by ticking to 00:59, then one TICK -> 01:00. From 09:59, one TICK -> 10:00 (carry through all digits).
- MIN_LIMIT=59, reach 59:59, one TICK -> 00:00, a single-cycle ROLLOVER pulse, RUNNING stays 1.
- Pause and edge-case inputs:
  - At 00:30, START_STOP edge -> PAUSE; 10 TICKs -> digits stay 00:30.
  - Holding START_STOP high for 20 cycles produces exactly one toggle.
  - CLEAR and START_STOP edges in the same cycle -> IDLE, 00:00.
- With BCD_TIMER_LAP_HOLD_EN:
  - LAP edge at 00:10, then 5 TICKs -> outputs show 00:10.
  - Second LAP edge -> outputs show 00:15 next cycle.
